// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-MODULUS up/down counter with parallel load,
// wrap or saturate boundary handling, and range-checked loads.
//
// Parameters
//   WIDTH    counter / data width
//   MODULUS  count range 0..MODULUS-1, legal 2..2**WIDTH
// Ports
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   enable    permit counting
//   load      parallel load of data_in (beats enable)
//   up_down   1 = count up, 0 = count down
//   sat_mode  0 = wrap at boundary, 1 = hold at boundary
//   data_in   load value
//   count     registered count
//   tc        combinational terminal count for the selected direction
//   wrap      registered one-cycle boundary-wrap pulse
//   sat       registered flag: count is being held at a boundary
//   load_err  registered one-cycle pulse: load value was >= MODULUS
module mod_n_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  // One extra bit so MODULUS = 2**WIDTH is representable.
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [EW-1:0] MOD_EXT = EW'(MODULUS);
  localparam logic [EW-1:0] MAX_EXT = EW'(MODULUS - 1);

  logic [EW-1:0]    count_ext;
  logic [EW-1:0]    data_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             load_err_nxt;

  assign count_ext = {1'b0, count};
  assign data_ext  = {1'b0, data_in};
  assign at_max    = (count_ext == MAX_EXT);
  assign at_zero   = (count == '0);

  // Terminal count follows direction only, not enable.
  assign tc = up_down ? at_max : at_zero;

  // Next-state: load > count > hold; flags default low so they pulse.
  always_comb begin
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    sat_nxt      = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (data_ext < MOD_EXT) begin
        count_nxt = data_in;
      end else begin
        count_nxt    = WIDTH'(MAX_EXT);
        load_err_nxt = 1'b1;
      end
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          if (sat_mode) begin
            sat_nxt = 1'b1;
          end else begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = WIDTH'(count_ext + EW'(1));
        end
      end else begin
        if (at_zero) begin
          if (sat_mode) begin
            sat_nxt = 1'b1;
          end else begin
            count_nxt = WIDTH'(MAX_EXT);
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = WIDTH'(count_ext - EW'(1));
        end
      end
    end
  end

  // State and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      sat      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      sat      <= sat_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed testbench for mod_n_updown_counter: default instance (4-bit, mod 14)
// plus parameter-sweep instances (3-bit mod 8, 5-bit mod 20).
module tb_mod_n_updown_counter;

  logic clock;
  logic reset;

  // Default instance
  logic       enable, load, up_down, sat_mode;
  logic [3:0] data_in, count;
  logic       tc, wrap, sat, load_err;

  // WIDTH=3, MODULUS=8
  logic       en3, ld3, ud3, sm3;
  logic [2:0] d3, c3;
  logic       tc3, wr3, st3, le3;

  // WIDTH=5, MODULUS=20
  logic       en5, ld5, ud5, sm5;
  logic [4:0] d5, c5;
  logic       tc5, wr5, st5, le5;

  int tests_run = 0;
  int fails     = 0;

  mod_n_updown_counter dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .up_down(up_down), .sat_mode(sat_mode), .data_in(data_in),
    .count(count), .tc(tc), .wrap(wrap), .sat(sat), .load_err(load_err)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8)) dut3 (
    .clock(clock), .reset(reset), .enable(en3), .load(ld3),
    .up_down(ud3), .sat_mode(sm3), .data_in(d3),
    .count(c3), .tc(tc3), .wrap(wr3), .sat(st3), .load_err(le3)
  );

  mod_n_updown_counter #(.WIDTH(5), .MODULUS(20)) dut5 (
    .clock(clock), .reset(reset), .enable(en5), .load(ld5),
    .up_down(ud5), .sat_mode(sm5), .data_in(d5),
    .count(c5), .tc(tc5), .wrap(wr5), .sat(st5), .load_err(le5)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge and settle away from it.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b1; data_in = 4'd9; enable = 1'b1; up_down = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b want 0", wrap); end
    tests_run++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b want 0", sat); end
    tests_run++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got %b want 0", load_err); end
    tests_run++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_up got %b want 0", tc); end
    tests_run++; if (c3 !== 3'd0 || c5 !== 5'd0) begin fails++; $display("FAIL reset_sweep got %0d/%0d want 0/0", c3, c5); end
  endtask

  task automatic test_wrap_up;
    logic [3:0] exp_c [4] = '{4'd12, 4'd13, 4'd0, 4'd1};
    logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    load = 1'b1; data_in = 4'd12; enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      tests_run++; if (count !== exp_c[i]) begin fails++; $display("FAIL wrap_up_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      tests_run++; if (wrap !== exp_w[i]) begin fails++; $display("FAIL wrap_up_pulse[%0d] got %b want %b", i, wrap, exp_w[i]); end
      tests_run++; if (tc !== exp_t[i]) begin fails++; $display("FAIL wrap_up_tc[%0d] got %b want %b", i, tc, exp_t[i]); end
    end
  endtask

  task automatic test_sat_down;
    logic [3:0] exp_c [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; data_in = 4'd1; enable = 1'b1; up_down = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      tests_run++; if (count !== exp_c[i]) begin fails++; $display("FAIL sat_down_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      tests_run++; if (sat !== exp_s[i]) begin fails++; $display("FAIL sat_down_sat[%0d] got %b want %b", i, sat, exp_s[i]); end
      tests_run++; if (wrap !== 1'b0) begin fails++; $display("FAIL sat_down_wrap[%0d] got %b want 0", i, wrap); end
    end
    tests_run++; if (tc !== 1'b1) begin fails++; $display("FAIL sat_down_tc got %b want 1", tc); end
    up_down = 1'b1;
    tick();
    tests_run++; if (count !== 4'd1) begin fails++; $display("FAIL sat_release_count got %0d want 1", count); end
    tests_run++; if (sat !== 1'b0) begin fails++; $display("FAIL sat_release_sat got %b want 0", sat); end
  endtask

  task automatic test_load_err;
    load = 1'b1; data_in = 4'd15; enable = 1'b0;
    tick();
    tests_run++; if (count !== 4'd13) begin fails++; $display("FAIL load15_count got %0d want 13", count); end
    tests_run++; if (load_err !== 1'b1) begin fails++; $display("FAIL load15_err got %b want 1", load_err); end
    load = 1'b0;
    tick();
    tests_run++; if (load_err !== 1'b0) begin fails++; $display("FAIL load_err_pulse got %b want 0", load_err); end
    load = 1'b1; data_in = 4'd13;
    tick();
    tests_run++; if (count !== 4'd13 || load_err !== 1'b0) begin fails++; $display("FAIL load13 got %0d/%b want 13/0", count, load_err); end
    data_in = 4'd14;
    tick();
    tests_run++; if (count !== 4'd13 || load_err !== 1'b1) begin fails++; $display("FAIL load14 got %0d/%b want 13/1", count, load_err); end
    data_in = 4'd0;
    tick();
    load = 1'b0;
    tests_run++; if (count !== 4'd0 || load_err !== 1'b0) begin fails++; $display("FAIL load0 got %0d/%b want 0/0", count, load_err); end
  endtask

  task automatic test_load_priority;
    load = 1'b1; data_in = 4'd7; enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
    tick();
    tests_run++; if (count !== 4'd7) begin fails++; $display("FAIL prio_load7 got %0d want 7", count); end
    data_in = 4'd5;
    tick();
    tests_run++; if (count !== 4'd5) begin fails++; $display("FAIL prio_load5 got %0d want 5", count); end
    load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (count !== 4'd5 || wrap !== 1'b0) begin fails++; $display("FAIL hold[%0d] got %0d/%b want 5/0", i, count, wrap); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_c [4] = '{4'd6, 4'd5, 4'd6, 4'd7};
    logic       dir   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_down = dir[i];
      tick();
      tests_run++; if (count !== exp_c[i]) begin fails++; $display("FAIL dirchg[%0d] got %0d want %0d", i, count, exp_c[i]); end
    end
  endtask

  task automatic test_wrap_down_and_sat_clear;
    load = 1'b1; data_in = 4'd0; up_down = 1'b0; sat_mode = 1'b0; enable = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tests_run++; if (count !== 4'd13 || wrap !== 1'b1) begin fails++; $display("FAIL wrap_down got %0d/%b want 13/1", count, wrap); end
    up_down = 1'b1; sat_mode = 1'b1;
    tick();
    tests_run++; if (count !== 4'd13 || sat !== 1'b1 || wrap !== 1'b0) begin fails++; $display("FAIL sat_up got %0d/%b/%b want 13/1/0", count, sat, wrap); end
    enable = 1'b0;
    tick();
    tests_run++; if (count !== 4'd13 || sat !== 1'b0) begin fails++; $display("FAIL sat_clear_en0 got %0d/%b want 13/0", count, sat); end
    enable = 1'b1;
    tick();
    load = 1'b1; data_in = 4'd2;
    tick();
    tests_run++; if (count !== 4'd2 || sat !== 1'b0) begin fails++; $display("FAIL sat_clear_load got %0d/%b want 2/0", count, sat); end
  endtask

  task automatic test_reset_mid;
    load = 1'b0; enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
    tick();
    reset = 1'b1; load = 1'b1; data_in = 4'd3;
    tick();
    tests_run++; if (count !== 4'd0) begin fails++; $display("FAIL reset_mid got %0d want 0", count); end
    reset = 1'b0;
    tick();
    tests_run++; if (count !== 4'd3) begin fails++; $display("FAIL post_reset_load got %0d want 3", count); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_sweep;
    int exp;
    // 3-bit, modulus 8: natural binary roll-over both ways
    ld3 = 1'b1; d3 = 3'd0; en3 = 1'b1; ud3 = 1'b1; sm3 = 1'b0;
    tick();
    ld3 = 1'b0;
    exp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (exp + 1) % 8;
      tests_run++; if (c3 !== 3'(exp) || wr3 !== (exp == 0)) begin fails++; $display("FAIL m8_up[%0d] got %0d/%b want %0d", i, c3, wr3, exp); end
    end
    ud3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (exp == 0) ? 7 : exp - 1;
      tests_run++; if (c3 !== 3'(exp) || wr3 !== (exp == 7)) begin fails++; $display("FAIL m8_down[%0d] got %0d/%b want %0d", i, c3, wr3, exp); end
    end
    tests_run++; if (tc3 !== (exp == 0) || st3 !== 1'b0 || le3 !== 1'b0) begin fails++; $display("FAIL m8_flags got %b/%b/%b", tc3, st3, le3); end
    en3 = 1'b0;

    // 5-bit, modulus 20
    ld5 = 1'b1; d5 = 5'd31; en5 = 1'b1; ud5 = 1'b1; sm5 = 1'b0;
    tick();
    ld5 = 1'b0;
    tests_run++; if (c5 !== 5'd19 || le5 !== 1'b1 || tc5 !== 1'b1) begin fails++; $display("FAIL m20_load31 got %0d/%b/%b want 19/1/1", c5, le5, tc5); end
    exp = 19;
    for (int i = 0; i < 25; i++) begin
      tick();
      exp = (exp + 1) % 20;
      tests_run++; if (c5 !== 5'(exp) || c5 >= 5'd20 || wr5 !== (exp == 0)) begin fails++; $display("FAIL m20_up[%0d] got %0d/%b want %0d", i, c5, wr5, exp); end
    end
    ud5 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      exp = (exp == 0) ? 19 : exp - 1;
      tests_run++; if (c5 !== 5'(exp) || c5 >= 5'd20 || wr5 !== (exp == 19)) begin fails++; $display("FAIL m20_down[%0d] got %0d/%b want %0d", i, c5, wr5, exp); end
    end
    ld5 = 1'b1; d5 = 5'd19; ud5 = 1'b1; sm5 = 1'b1;
    tick();
    ld5 = 1'b0;
    tick();
    tests_run++; if (c5 !== 5'd19 || st5 !== 1'b1 || wr5 !== 1'b0) begin fails++; $display("FAIL m20_sat got %0d/%b/%b want 19/1/0", c5, st5, wr5); end
    en5 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; up_down = 1'b1; sat_mode = 1'b0; data_in = '0;
    en3 = 1'b0; ld3 = 1'b0; ud3 = 1'b1; sm3 = 1'b0; d3 = '0;
    en5 = 1'b0; ld5 = 1'b0; ud5 = 1'b1; sm5 = 1'b0; d5 = '0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_err();
    test_load_priority();
    test_back_to_back();
    test_wrap_down_and_sat_clear();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
